traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//  Runs the two-lane traffic light cycle in normal mode from the green/yellow/red times committed by configuration mode.
//  Counts down each lane's remaining seconds on a 1 Hz tick and drives both lanes' lamps.
//  Sits beside configuration mode: mode select via enable, times consumed only at cycle boundaries.
// PARAMETERS
//  MAX_TIME    99  largest legal phase time (s)
//  DEF_GREEN   25  fallback green time when committed config is invalid
//  DEF_YELLOW  5   fallback yellow time; fallback red = DEF_GREEN+DEF_YELLOW
// PORTS
//  clk         in   1  system clock; single clock domain
//  reset       in   1  synchronous, active-high reset
//  enable      in   3  mode select; 3'b001 = run normal cycle, anything else = idle
//  tick        in   1  one-clk pulse per second, synchronous to clk
//  greenTime   in   7  committed green time (s)
//  yellowTime  in   7  committed yellow time (s)
//  redTime     in   7  committed red time (s); legal only if == green+yellow
//  lightLane1  out  3  lane 1 lamps, one-hot {R,Y,G}
//  lightLane2  out  3  lane 2 lamps, one-hot {R,Y,G}
//  timeLane1   out  7  lane 1 remaining seconds
//  timeLane2   out  7  lane 2 remaining seconds
//  state       out  3  IDLE=0, G1=1, Y1=2, G2=3, Y2=4, FLASH=5
//  cfgError    out  1  high while fallback times are in use
// BEHAVIOUR
//  - All outputs registered; reset: state=IDLE, lights=3'b100 both, timeLane*=0, cfgError=0, shadow times=0.
//  - Shadow regs G/Y/R sampled only on entry to G1 (from IDLE or from Y2); mid-cycle input changes are ignored.
//  - Valid config: G>=1, Y>=1, R<=MAX_TIME, R==G+Y (8-bit compare, no 7-bit wrap). Invalid -> use DEF_*, cfgError=1.
//    cfgError re-evaluated at every G1 entry.
//  - IDLE->G1: first clk with enable==3'b001, no tick needed; timeLane1=G, timeLane2=R.
//  - Phase order: G1 -> Y1 -> G2 -> Y2 -> G1.
//    G1/Y1: lane1 G/Y, lane2 R. G2/Y2: lane2 G/Y, lane1 R.
//  - On tick, the running lane's timer decrements. When the timer is 1, the tick advances the phase and reloads instead:
//    G1->Y1: timeLane1=Y, timeLane2 keeps counting.
//    Y1->G2: timeLane2=G, timeLane1=R.
//    G2->Y2: timeLane2=Y.
//    Y2->G1: resample shadows, reload both.
//  - Red lane's timer decrements on every tick and reaches 1 on the same tick as the green lane's yellow ends (R==G+Y).
//  - Displayed range R..1; 0 only in IDLE/FLASH. Outputs update on the clk edge where tick=1 (1-cycle latency).
//  - enable leaves 3'b001 in any phase: next edge -> IDLE, both red, timers 0. This has priority over a simultaneous tick.
//  - reset mid-cycle: next edge all outputs at reset values, regardless of tick/enable.
//  - tick while IDLE: ignored. tick held high over multiple clks: each high clk counts as a tick (source must pulse).
// CONFIGURATION
//  NIGHT_FLASH_EN defined:
//    - enable==3'b100 -> FLASH: both lanes yellow; the yellow toggles on/off (3'b010/3'b000) each tick, starting on.
//    - timeLane*=0 in FLASH; leaving 3'b100 -> IDLE; 3'b001 then restarts at G1.
//  NIGHT_FLASH_EN undefined: FLASH unreachable; 3'b100 treated as idle.
// TESTING
//  - reset=1 for 2 clks -> state=0, lights 3'b100/3'b100, timers 0, cfgError=0.
//  - G=5,Y=3,R=8, enable=001, 40 ticks:
//      G1 shows 5..1/8..4; Y1 3..1/3..1; G2 8..4/5..1; Y2 3..1/3..1; period exactly 16 ticks.
//  - G=5,Y=3,R=9 (invalid), enable=001 -> cfgError=1, timeLane1=25, timeLane2=30.
//  - Fix R=8 mid-cycle -> unchanged until next Y2->G1, then cfgError=0 and 5/8.
//  - G=7,Y=2,R=9 changed to G=4,Y=1,R=5 during G2 -> current cycle finishes with 7/2/9; next G1 shows 4/5.
//  - enable 001->010 on same clk as tick in Y1 -> IDLE, both red, timers 0, no phase advance.
//  - With NIGHT_FLASH_EN: enable=100, 4 ticks -> both lanes 010,000,010,000; then enable=001 -> G1 with fresh times.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Two-lane traffic light sequencer: runs G1/Y1/G2/Y2 from shadowed config times on a 1 Hz tick.
// Optional night-flash mode is compiled in with `define NIGHT_FLASH_EN.
module traffic_phase_sequencer #(
    parameter int unsigned MAX_TIME   = 99,
    parameter int unsigned DEF_GREEN  = 25,
    parameter int unsigned DEF_YELLOW = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] enable,
    input  logic       tick,
    input  logic [6:0] greenTime,
    input  logic [6:0] yellowTime,
    input  logic [6:0] redTime,
    output logic [2:0] lightLane1,
    output logic [2:0] lightLane2,
    output logic [6:0] timeLane1,
    output logic [6:0] timeLane2,
    output logic [2:0] state,
    output logic       cfgError
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_G1    = 3'd1,
        ST_Y1    = 3'd2,
        ST_G2    = 3'd3,
        ST_Y2    = 3'd4,
        ST_FLASH = 3'd5
    } phase_e;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] EN_RUN   = 3'b001;
    localparam logic [2:0] EN_FLASH = 3'b100;

    localparam logic [6:0] DEF_G7  = 7'(DEF_GREEN);
    localparam logic [6:0] DEF_Y7  = 7'(DEF_YELLOW);
    localparam logic [6:0] DEF_R7  = 7'(DEF_GREEN + DEF_YELLOW);
    localparam logic [7:0] MAX_T8  = 8'(MAX_TIME);

    phase_e     state_q, state_d;
    logic [6:0] t1_q, t1_d;
    logic [6:0] t2_q, t2_d;
    logic [2:0] light1_q, light1_d;
    logic [2:0] light2_q, light2_d;
    logic [6:0] green_q, green_d;
    logic [6:0] yellow_q, yellow_d;
    logic [6:0] red_q, red_d;
    logic       cfg_err_q, cfg_err_d;
    logic       flash_on_q, flash_on_d;

    logic       run_req;
    logic       flash_req;
    logic       load_cycle;
    logic       cfg_valid;
    logic [7:0] sum8;
    logic [6:0] samp_g, samp_y, samp_r;

    assign run_req = (enable == EN_RUN);
`ifdef NIGHT_FLASH_EN
    assign flash_req = (enable == EN_FLASH);
`else
    assign flash_req = 1'b0;
`endif

    // Sum widened to 8 bits so e.g. 100+30 cannot alias a small redTime.
    always_comb begin
        sum8      = {1'b0, greenTime} + {1'b0, yellowTime};
        cfg_valid = (greenTime != '0) && (yellowTime != '0) &&
                    ({1'b0, redTime} <= MAX_T8) && ({1'b0, redTime} == sum8);
        samp_g    = cfg_valid ? greenTime  : DEF_G7;
        samp_y    = cfg_valid ? yellowTime : DEF_Y7;
        samp_r    = cfg_valid ? redTime    : DEF_R7;
    end

    always_comb begin
        state_d    = state_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        green_d    = green_q;
        yellow_d   = yellow_q;
        red_d      = red_q;
        cfg_err_d  = cfg_err_q;
        flash_on_d = flash_on_q;
        load_cycle = 1'b0;
        light1_d   = LAMP_R;
        light2_d   = LAMP_R;

        if (flash_req) begin
            if (state_q != ST_FLASH) begin
                state_d    = ST_FLASH;
                flash_on_d = 1'b1;
            end else if (tick) begin
                flash_on_d = ~flash_on_q;
            end
            t1_d = '0;
            t2_d = '0;
        end else if (!run_req || state_q == ST_FLASH) begin
            state_d = ST_IDLE;
            t1_d    = '0;
            t2_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: load_cycle = 1'b1;
                ST_G1: if (tick) begin
                    if (t1_q == 7'd1) begin
                        state_d = ST_Y1;
                        t1_d    = yellow_q;
                    end else begin
                        t1_d = t1_q - 7'd1;
                    end
                    t2_d = t2_q - 7'd1;
                end
                ST_Y1: if (tick) begin
                    if (t1_q == 7'd1) begin
                        state_d = ST_G2;
                        t1_d    = red_q;
                        t2_d    = green_q;
                    end else begin
                        t1_d = t1_q - 7'd1;
                        t2_d = t2_q - 7'd1;
                    end
                end
                ST_G2: if (tick) begin
                    if (t2_q == 7'd1) begin
                        state_d = ST_Y2;
                        t2_d    = yellow_q;
                    end else begin
                        t2_d = t2_q - 7'd1;
                    end
                    t1_d = t1_q - 7'd1;
                end
                ST_Y2: if (tick) begin
                    if (t2_q == 7'd1) begin
                        load_cycle = 1'b1;
                    end else begin
                        t1_d = t1_q - 7'd1;
                        t2_d = t2_q - 7'd1;
                    end
                end
                default: ;
            endcase
        end

        // Config is only consumed here, so mid-cycle input changes wait for the next G1.
        if (load_cycle) begin
            state_d   = ST_G1;
            green_d   = samp_g;
            yellow_d  = samp_y;
            red_d     = samp_r;
            cfg_err_d = ~cfg_valid;
            t1_d      = samp_g;
            t2_d      = samp_r;
        end

        case (state_d)
            ST_G1:    light1_d = LAMP_G;
            ST_Y1:    light1_d = LAMP_Y;
            ST_G2:    light2_d = LAMP_G;
            ST_Y2:    light2_d = LAMP_Y;
            ST_FLASH: begin
                light1_d = flash_on_d ? LAMP_Y : '0;
                light2_d = flash_on_d ? LAMP_Y : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            t1_q       <= '0;
            t2_q       <= '0;
            light1_q   <= LAMP_R;
            light2_q   <= LAMP_R;
            green_q    <= '0;
            yellow_q   <= '0;
            red_q      <= '0;
            cfg_err_q  <= 1'b0;
            flash_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            light1_q   <= light1_d;
            light2_q   <= light2_d;
            green_q    <= green_d;
            yellow_q   <= yellow_d;
            red_q      <= red_d;
            cfg_err_q  <= cfg_err_d;
            flash_on_q <= flash_on_d;
        end
    end

    assign lightLane1 = light1_q;
    assign lightLane2 = light2_q;
    assign timeLane1  = t1_q;
    assign timeLane2  = t2_q;
    assign state      = state_q;
    assign cfgError   = cfg_err_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: tick-count model compared every cycle plus directed literal checks.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] enable;
    logic       tick;
    logic [6:0] greenTime, yellowTime, redTime;
    logic [2:0] lightLane1, lightLane2;
    logic [6:0] timeLane1, timeLane2;
    logic [2:0] state;
    logic       cfgError;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

`ifdef NIGHT_FLASH_EN
    localparam bit HAS_FLASH = 1'b1;
`else
    localparam bit HAS_FLASH = 1'b0;
`endif

    traffic_phase_sequencer #(.MAX_TIME(99), .DEF_GREEN(25), .DEF_YELLOW(5)) dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .greenTime(greenTime), .yellowTime(yellowTime), .redTime(redTime),
        .lightLane1(lightLane1), .lightLane2(lightLane2),
        .timeLane1(timeLane1), .timeLane2(timeLane2),
        .state(state), .cfgError(cfgError)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=run 2=flash; in run mode k counts ticks since the last G1 entry.
    int m_mode, m_k, m_g, m_y, m_r, m_err;
    bit m_on;

    task automatic model_start();
        int g, y, r;
        g = int'(greenTime); y = int'(yellowTime); r = int'(redTime);
        if (g >= 1 && y >= 1 && r <= 99 && r == g + y) begin
            m_g = g; m_y = y; m_r = r; m_err = 0;
        end else begin
            m_g = 25; m_y = 5; m_r = 30; m_err = 1;
        end
        m_k = 0;
        m_mode = 1;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_k = 0; m_g = 0; m_y = 0; m_r = 0; m_err = 0; m_on = 1'b0;
        end else if (HAS_FLASH && enable == 3'b100) begin
            if (m_mode != 2) begin
                m_mode = 2; m_on = 1'b1;
            end else if (tick) begin
                m_on = ~m_on;
            end
        end else if (enable != 3'b001 || m_mode == 2) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            model_start();
        end else if (tick) begin
            m_k++;
            if (m_k == 2 * m_r) model_start();
        end
    end

    always @(negedge clk) begin
        int e_st, e_l1, e_l2, e_t1, e_t2;
        if (chk_en) begin
            e_st = 0; e_l1 = 4; e_l2 = 4; e_t1 = 0; e_t2 = 0;
            if (m_mode == 2) begin
                e_st = 5; e_l1 = m_on ? 2 : 0; e_l2 = e_l1;
            end else if (m_mode == 1) begin
                if (m_k < m_g) begin
                    e_st = 1; e_l1 = 1; e_t1 = m_g - m_k; e_t2 = m_r - m_k;
                end else if (m_k < m_r) begin
                    e_st = 2; e_l1 = 2; e_t1 = m_r - m_k; e_t2 = m_r - m_k;
                end else if (m_k < m_r + m_g) begin
                    e_st = 3; e_l2 = 1; e_t1 = 2 * m_r - m_k; e_t2 = m_g - (m_k - m_r);
                end else begin
                    e_st = 4; e_l2 = 2; e_t1 = 2 * m_r - m_k; e_t2 = 2 * m_r - m_k;
                end
            end
            check("model.state",  int'(state),      e_st);
            check("model.light1", int'(lightLane1), e_l1);
            check("model.light2", int'(lightLane2), e_l2);
            check("model.time1",  int'(timeLane1),  e_t1);
            check("model.time2",  int'(timeLane2),  e_t2);
            check("model.cfgErr", int'(cfgError),   m_err);
        end
    end

    // Inputs change 1 time unit after the edge; returns 1 unit after the edge that consumed them.
    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    task automatic set_cfg(input int g, input int y, input int r);
        greenTime = 7'(g); yellowTime = 7'(y); redTime = 7'(r);
    endtask

    task automatic expect_out(input string tag, input int st, input int l1, input int l2,
                              input int t1, input int t2, input int err);
        check({tag, ".state"},  int'(state),      st);
        check({tag, ".light1"}, int'(lightLane1), l1);
        check({tag, ".light2"}, int'(lightLane2), l2);
        check({tag, ".time1"},  int'(timeLane1),  t1);
        check({tag, ".time2"},  int'(timeLane2),  t2);
        check({tag, ".cfgErr"}, int'(cfgError),   err);
    endtask

    typedef struct { int g; int y; int r; int err; int t1; int t2; } cfg_vec_t;
    cfg_vec_t bvec[6] = '{
        '{50, 49,  99, 0, 50, 99},
        '{ 0,  5,   5, 1, 25, 30},
        '{100, 30,  2, 1, 25, 30},
        '{ 5,  0,   5, 1, 25, 30},
        '{60, 40, 100, 1, 25, 30},
        '{ 1,  1,   2, 0,  1,  2}
    };

    initial begin
        reset = 1'b1; enable = 3'b000; tick = 1'b0;
        set_cfg(5, 3, 8);
        cyc(1'b0); cyc(1'b0);
        expect_out("reset", 0, 4, 4, 0, 0, 0);
        chk_en = 1'b1;

        reset = 1'b0; enable = 3'b001;
        cyc(1'b0);
        expect_out("start", 1, 1, 4, 5, 8, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1);
            if (i == 4)  expect_out("y1_entry", 2, 2, 4, 3, 3, 0);
            if (i == 7)  expect_out("g2_entry", 3, 4, 1, 8, 5, 0);
            if (i == 12) expect_out("y2_entry", 4, 4, 2, 3, 3, 0);
            if (i == 15) expect_out("period16", 1, 1, 4, 5, 8, 0);
            cyc(1'b0);
        end
        expect_out("after40", 3, 4, 1, 8, 5, 0);

        enable = 3'b000; cyc(1'b0);
        expect_out("to_idle", 0, 4, 4, 0, 0, 0);
        set_cfg(5, 3, 9); enable = 3'b001; cyc(1'b0);
        expect_out("invalid", 1, 1, 4, 25, 30, 1);
        set_cfg(5, 3, 8);
        ticks(10);
        expect_out("fix_ignored", 1, 1, 4, 15, 20, 1);
        ticks(50);
        expect_out("fix_applied", 1, 1, 4, 5, 8, 0);

        enable = 3'b000; cyc(1'b0);
        set_cfg(7, 2, 9); enable = 3'b001; cyc(1'b0);
        expect_out("cfg729", 1, 1, 4, 7, 9, 0);
        ticks(9);
        expect_out("g2_729", 3, 4, 1, 9, 7, 0);
        set_cfg(4, 1, 5);
        ticks(8);
        expect_out("y2_end_729", 4, 4, 2, 1, 1, 0);
        ticks(1);
        expect_out("new_cfg415", 1, 1, 4, 4, 5, 0);

        ticks(4);
        expect_out("y1_415", 2, 2, 4, 1, 1, 0);
        enable = 3'b010; cyc(1'b1);
        expect_out("abort_tick", 0, 4, 4, 0, 0, 0);
        cyc(1'b1);
        expect_out("idle_tick", 0, 4, 4, 0, 0, 0);

        set_cfg(4, 1, 6); enable = 3'b001; cyc(1'b0);
        expect_out("invalid416", 1, 1, 4, 25, 30, 1);
        ticks(2);
        reset = 1'b1; cyc(1'b1);
        expect_out("mid_reset", 0, 4, 4, 0, 0, 0);
        enable = 3'b000; cyc(1'b0);
        reset = 1'b0;

        foreach (bvec[i]) begin
            enable = 3'b000; cyc(1'b0);
            set_cfg(bvec[i].g, bvec[i].y, bvec[i].r);
            enable = 3'b001; cyc(1'b0);
            expect_out($sformatf("bound%0d", i), 1, 1, 4, bvec[i].t1, bvec[i].t2, bvec[i].err);
            ticks(5);
        end

        enable = 3'b000; cyc(1'b0);
        set_cfg(5, 3, 8);
`ifdef NIGHT_FLASH_EN
        enable = 3'b100; cyc(1'b0);
        expect_out("flash_on", 5, 2, 2, 0, 0, 0);
        cyc(1'b1); expect_out("flash_t1", 5, 0, 0, 0, 0, 0);
        cyc(1'b1); expect_out("flash_t2", 5, 2, 2, 0, 0, 0);
        cyc(1'b1); expect_out("flash_t3", 5, 0, 0, 0, 0, 0);
        cyc(1'b1); expect_out("flash_t4", 5, 2, 2, 0, 0, 0);
        enable = 3'b001; cyc(1'b0);
        expect_out("flash_exit", 0, 4, 4, 0, 0, 0);
        cyc(1'b0);
        expect_out("flash_restart", 1, 1, 4, 5, 8, 0);
`else
        enable = 3'b100; cyc(1'b1);
        expect_out("en100_idle", 0, 4, 4, 0, 0, 0);
`endif
        cyc(1'b0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
